sram_pattern_tester: RTL and testbench
======================================

Name: sram_pattern_tester

Overview:
Self-running SRAM/PRAM pattern test engine that produces the 16-bit word shown on the board's 4-digit hex display.
- Writes a deterministic address-derived pattern across the whole memory, then reads it back and compares.
- Repeats the write/read with the inverted pattern so every data bit is tested in both polarities.
- Drives the memory control pins directly.
- Publishes progress, then the result, on `disp`, which connects straight to the `x` input of the hex display driver.

Parameters:
- ADDR_W, 16, memory address width (2..16); all 2^ADDR_W locations are tested.
- WAIT_CYCLES, 2, clocks of strobe-active time per access (1..15).
- SEED, 16'hA5C3, pattern key: pattern(a) = {a zero-extended to 16} XOR SEED.

Ports:
- clk, in, 1, system clock.
- clr_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a test run (level sampled in IDLE/DONE).
- mem_addr, out, ADDR_W, memory address.
- mem_dout, out, 16, write data.
- mem_drive, out, 1, 1 = top level enables the data-bus tristate.
- mem_din, in, 16, read data from the bus.
- mem_ce_n, out, 1, chip enable.
- mem_we_n, out, 1, write strobe.
- mem_oe_n, out, 1, output enable.
- busy, out, 1, test in progress.
- done, out, 1, test finished; held until the next start or reset.
- pass, out, 1, valid while done; 1 = zero errors.
- err_count, out, 16, mismatching reads; saturates at 16'hFFFF.
- first_fail, out, 16, address of the first mismatch (see Optional Feature).
- disp, out, 16, value for the hex display.

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_ce_n = mem_we_n = mem_oe_n = 1.
  - mem_drive = 0.
  - mem_addr = 0, mem_dout = 0.
  - busy = done = pass = 0.
  - err_count = 0, first_fail = 0, disp = 0.
  - State IDLE, pass_sel = 0.
- Reset asserted mid-operation forces these values immediately (asynchronously) and releases the bus.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, TURN, R_SETUP, R_STROBE, R_SAMPLE, DONE.
- IDLE or DONE with start = 1:
  - Clear err_count, first_fail, pass, done, pass_sel, address.
  - Set busy; go to W_SETUP.
- start is ignored in all other states.
- Write cycle (4 + WAIT_CYCLES − 2 clocks per location; 4 at default):
  - W_SETUP, 1 clk: mem_ce_n = 0; addr and data valid; mem_drive = 1; mem_we_n = 1.
  - W_STROBE, WAIT_CYCLES clks: mem_we_n = 0.
  - W_HOLD, 1 clk: mem_we_n = 1; addr, data and mem_drive unchanged.
  - Data = pattern(addr), or ~pattern(addr) when pass_sel = 1.
  - After W_HOLD: if addr = 2^ADDR_W−1 then addr ← 0 and go to TURN; else addr+1 and go to W_SETUP.
- TURN, 1 clk: mem_drive = 0, mem_ce_n = 1 (bus turnaround). Next state is R_SETUP, or W_SETUP when entered from the read pass.
- Read cycle:
  - R_SETUP, 1 clk: mem_ce_n = 0, mem_oe_n = 0, mem_drive = 0.
  - R_STROBE, WAIT_CYCLES clks.
  - R_SAMPLE, 1 clk: mem_din is registered and compared with the expected word.
  - On mismatch: err_count increments, saturating at 16'hFFFF.
  - After R_SAMPLE, the last address moves on as follows:
    - pass_sel = 0: pass_sel ← 1, addr ← 0, go to TURN, then to W_SETUP.
    - pass_sel = 1: go to DONE.
- DONE:
  - busy = 0, done = 1, pass = (err_count == 0).
  - mem_ce_n = mem_oe_n = 1.
- disp:
  - IDLE after reset: 0.
  - busy: mem_addr zero-extended.
  - DONE: err_count.
- Simultaneous error and saturation: the count stays at 16'hFFFF.

Optional Feature:
Macro SRAM_TEST_FIRST_FAIL_EN.
- Defined:
  - first_fail captures mem_addr (zero-extended) on the first mismatch of a run; later mismatches do not overwrite it.
  - In DONE with err_count ≠ 0, disp shows first_fail instead of err_count.
- Undefined: first_fail is tied to 0 and disp behaves as in Behaviour.

Decomposition:
- Package `sram_test_pkg`:
  - State encoding constants.
  - Default SEED.
  - Default WAIT_CYCLES.
- Sub-module `sram_cycle_timer`:
  - Loadable down-counter for WAIT_CYCLES.
  - Inputs: load, count value.
  - Output: expire pulse.
  - Used by both strobe states.

Test Plan (ADDR_W=4, WAIT_CYCLES=2, behavioural SRAM model):
1. Hold clr_n = 0 while start = 1 → strobes all 1, mem_drive = 0, busy = 0, disp = 0. Release, then pulse clr_n low during W_STROBE → mem_we_n goes to 1 asynchronously.
2. Good memory, start pulsed at edge k:
   - busy from k, 16 writes then 16 reads per pass, two passes.
   - done rises at edge k+260.
   - pass = 1, err_count = 0, disp = 16'h0000.
   - Location 5 written 16'hA5C6, then 16'h5A39.
3. Model forces data bit 3 of address 5 to 0 → pass 0 is clean, pass 1 fails once: err_count = 1, pass = 0. With the macro, first_fail = 16'h0005 and disp = 16'h0005; without it, disp = 16'h0001.
4. mem_din stuck at 16'hFFFF → all 32 reads mismatch (no pattern word is FFFF): err_count = 16'h0020, pass = 0.
5. start re-pulsed while busy → no restart; done still at k+260. Then start in DONE → err_count and done clear, a new run begins, and busy = 1 on the next edge.
6. Bus protocol check across a full run:
   - mem_we_n and mem_oe_n are never 0 together.
   - mem_drive is never 1 while mem_oe_n = 0.
   - Addr and data are stable for the whole W_SETUP…W_HOLD window.

Source files
------------

// File: rtl/sram_test_pkg.sv
// Shared state encoding and default configuration for the SRAM pattern tester.
package sram_test_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_STROBE,
    S_W_HOLD,
    S_TURN,
    S_R_SETUP,
    S_R_STROBE,
    S_R_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [15:0] DEF_SEED        = 16'hA5C3;
  localparam int          DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter timing the strobe phase of each memory access.
module sram_cycle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] count_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q;
  logic          armed_q;

  // expire_o fires once on the last strobe clock, then disarms until reloaded
  assign expire_o = armed_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= count_i - CW'(1);
      armed_q <= 1'b1;
    end else if (expire_o) begin
      armed_q <= 1'b0;
    end else if (cnt_q != '0) begin
      cnt_q   <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/sram_pattern_tester.sv
// Self-running write/read/compare engine over the whole SRAM, both data polarities.
// Optional macro SRAM_TEST_FIRST_FAIL_EN: capture and display the first failing address.
module sram_pattern_tester
  import sram_test_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [15:0] SEED        = DEF_SEED
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_dout,
  output logic              mem_drive,
  input  logic [15:0]       mem_din,
  output logic              mem_ce_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       first_fail,
  output logic [15:0]       disp
);

  state_e            state_q;
  logic              pass_sel_q, rd_turn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       dout_q, err_q, disp_q;
  logic              drive_q, ce_n_q, we_n_q, oe_n_q;
  logic              busy_q, done_q, pass_q;
  logic              tmr_load, tmr_expire, mismatch;
  logic [15:0]       done_disp;

  function automatic logic [15:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    return (16'(a) ^ SEED) ^ {16{inv}};
  endfunction

  assign tmr_load = (state_q == S_W_SETUP) || (state_q == S_R_SETUP);
  assign mismatch = (mem_din != pat(addr_q, pass_sel_q));

  sram_cycle_timer #(.CW(4)) u_timer (
    .clk      (clk),
    .rst_n    (clr_n),
    .load_i   (tmr_load),
    .count_i  (4'(WAIT_CYCLES)),
    .expire_o (tmr_expire)
  );

`ifdef SRAM_TEST_FIRST_FAIL_EN
  logic [15:0] ff_q;
  assign first_fail = ff_q;
  assign done_disp  = (err_q != '0) ? ff_q : err_q;
`else
  assign first_fail = '0;
  assign done_disp  = err_q;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      pass_sel_q <= 1'b0;
      rd_turn_q  <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      drive_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      disp_q     <= '0;
`ifdef SRAM_TEST_FIRST_FAIL_EN
      ff_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_W_SETUP;
            pass_sel_q <= 1'b0;
            rd_turn_q  <= 1'b0;
            addr_q     <= '0;
            dout_q     <= pat('0, 1'b0);
            drive_q    <= 1'b1;
            ce_n_q     <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            disp_q     <= '0;
`ifdef SRAM_TEST_FIRST_FAIL_EN
            ff_q       <= '0;
`endif
          end else if (state_q == S_DONE) begin
            // status settles one clock after the bus is released
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == '0);
            disp_q <= done_disp;
          end
        end
        S_W_SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= S_W_STROBE;
        end
        S_W_STROBE: begin
          if (tmr_expire) begin
            we_n_q  <= 1'b1;
            state_q <= S_W_HOLD;
          end
        end
        S_W_HOLD: begin
          if (addr_q == '1) begin
            addr_q    <= '0;
            disp_q    <= '0;
            drive_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            rd_turn_q <= 1'b0;
            state_q   <= S_TURN;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            disp_q  <= 16'(addr_q + ADDR_W'(1));
            dout_q  <= pat(addr_q + ADDR_W'(1), pass_sel_q);
            state_q <= S_W_SETUP;
          end
        end
        S_TURN: begin
          ce_n_q <= 1'b0;
          if (rd_turn_q) begin
            rd_turn_q <= 1'b0;
            drive_q   <= 1'b1;
            dout_q    <= pat(addr_q, pass_sel_q);
            state_q   <= S_W_SETUP;
          end else begin
            oe_n_q  <= 1'b0;
            state_q <= S_R_SETUP;
          end
        end
        S_R_SETUP: state_q <= S_R_STROBE;
        S_R_STROBE: begin
          if (tmr_expire) state_q <= S_R_SAMPLE;
        end
        S_R_SAMPLE: begin
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
`ifdef SRAM_TEST_FIRST_FAIL_EN
            if (err_q == '0) ff_q <= 16'(addr_q);
`endif
          end
          if (addr_q != '1) begin
            addr_q  <= addr_q + ADDR_W'(1);
            disp_q  <= 16'(addr_q + ADDR_W'(1));
            state_q <= S_R_SETUP;
          end else begin
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            if (!pass_sel_q) begin
              pass_sel_q <= 1'b1;
              rd_turn_q  <= 1'b1;
              addr_q     <= '0;
              disp_q     <= '0;
              state_q    <= S_TURN;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_dout  = dout_q;
  assign mem_drive = drive_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_oe_n  = oe_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign disp      = disp_q;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Randomized-fault bench: SRAM model plus a timeline model of the whole test run.
module tb_sram_pattern_tester;

  localparam int          AW   = 4;
  localparam logic [15:0] SEED = 16'hA5C3;

  logic          clk, clr_n, start;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dout, mem_din, err_count, first_fail, disp;
  logic          mem_drive, mem_ce_n, mem_we_n, mem_oe_n, busy, done, pass;

  sram_pattern_tester #(.ADDR_W(AW), .WAIT_CYCLES(2), .SEED(SEED)) dut (
    .clk(clk), .clr_n(clr_n), .start(start),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_drive(mem_drive), .mem_din(mem_din),
    .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .disp(disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, k = 0, mode = 0, exp_err = 0, exp_ff = 0, fault_a = 5;
  bit mon_on = 1'b0;
  logic [15:0] mem [16];
  logic [15:0] log5 [$];

  always @(posedge clk) cyc <= cyc + 1;

  // fault modes: 0 good, 1 data bit 3 of one address reads as 0, 2 bus stuck at FFFF
  function automatic logic [15:0] fault(input int m, input int fa, input logic [3:0] a, input logic [15:0] w);
    if (m == 1) return (int'(a) == fa) ? (w & 16'hFFF7) : w;
    if (m == 2) return 16'hFFFF;
    return w;
  endfunction

  assign mem_din = (!mem_ce_n && !mem_oe_n) ? fault(mode, fault_a, mem_addr, mem[mem_addr]) : 16'h0000;

  always @(posedge mem_we_n) begin
    if (!mem_ce_n && mem_drive) begin
      mem[mem_addr] = mem_dout;
      if (mem_addr == 4'd5) log5.push_back(mem_dout);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h expected %h", nm, cyc - k, act, exp);
    end
  endtask

  function automatic void model_run(input int m, input int fa, output int err, output int ff);
    logic [15:0] w;
    err = 0; ff = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++) begin
        w = (16'(a) ^ SEED) ^ (p == 1 ? 16'hFFFF : 16'h0000);
        if (fault(m, fa, 4'(a), w) != w) begin
          if (err == 0) ff = a;
          err++;
        end
      end
  endfunction

  typedef struct packed {
    logic        ce_n, we_n, oe_n, drive, busy, done;
    logic [3:0]  addr;
    logic        chk_dout;
    logic [15:0] dout;
  } exp_t;

  // t counts clocks after the edge that accepted start; each pass is 16x4 writes,
  // a turnaround, 16x4 reads and (first pass only) another turnaround
  function automatic exp_t model_at(input int t);
    exp_t e;
    int p, r, a;
    e = '0;
    e.ce_n = 1'b1; e.we_n = 1'b1; e.oe_n = 1'b1; e.busy = 1'b1;
    if (t >= 260) begin
      e.busy = 1'b0; e.done = 1'b1; e.addr = 4'd15;
    end else if (t == 259) begin
      e.addr = 4'd15;
    end else begin
      p = t / 130; r = t % 130;
      if (r < 64) begin
        a = r / 4;
        e.ce_n = 1'b0; e.drive = 1'b1; e.addr = 4'(a);
        e.we_n = ((r % 4) == 1 || (r % 4) == 2) ? 1'b0 : 1'b1;
        e.chk_dout = 1'b1;
        e.dout = (16'(a) ^ SEED) ^ (p == 1 ? 16'hFFFF : 16'h0000);
      end else if (r >= 65 && r < 129) begin
        e.ce_n = 1'b0; e.oe_n = 1'b0; e.addr = 4'((r - 65) / 4);
      end
    end
    return e;
  endfunction

  function automatic logic [15:0] exp_done_disp();
`ifdef SRAM_TEST_FIRST_FAIL_EN
    return (exp_err != 0) ? 16'(exp_ff) : 16'(exp_err);
`else
    return 16'(exp_err);
`endif
  endfunction

  always @(posedge clk) begin : mon
    int t;
    exp_t e;
    #2;
    t = cyc - k;
    if (mon_on && t >= 0 && t <= 265) begin
      e = model_at(t);
      chk("ce_n", 32'(mem_ce_n), 32'(e.ce_n));
      chk("we_n", 32'(mem_we_n), 32'(e.we_n));
      chk("oe_n", 32'(mem_oe_n), 32'(e.oe_n));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("proto_we_oe", 32'(mem_we_n | mem_oe_n), 32'd1);
      chk("proto_drive_oe", 32'(!(mem_drive && !mem_oe_n)), 32'd1);
      if (t < 260) begin
        chk("drive", 32'(mem_drive), 32'(e.drive));
        chk("addr", 32'(mem_addr), 32'(e.addr));
        chk("disp_busy", 32'(disp), 32'(e.addr));
        if (e.chk_dout) chk("dout", 32'(mem_dout), 32'(e.dout));
      end else begin
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("pass", 32'(pass), 32'(exp_err == 0));
        chk("disp_done", 32'(disp), 32'(exp_done_disp()));
`ifdef SRAM_TEST_FIRST_FAIL_EN
        chk("first_fail", 32'(first_fail), 32'(exp_err != 0 ? exp_ff : 0));
`else
        chk("first_fail", 32'(first_fail), 32'd0);
`endif
      end
      if (t == 0) begin
        chk("err_clear", 32'(err_count), 32'd0);
        chk("ff_clear", 32'(first_fail), 32'd0);
      end
    end
  end

  task automatic run(input int m, input int fa, input bit repulse);
    mode = m; fault_a = fa;
    log5.delete();
    model_run(m, fa, exp_err, exp_ff);
    @(negedge clk); start = 1'b1; k = cyc + 1; mon_on = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc - k < 264) begin
      @(negedge clk);
      start = (repulse && (cyc - k == 100)) ? 1'b1 : 1'b0;
    end
    mon_on = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    clr_n = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ce_n", 32'(mem_ce_n), 32'd1);
    chk("rst_we_n", 32'(mem_we_n), 32'd1);
    chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rst_drive", 32'(mem_drive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    start = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("strobe_we_n", 32'(mem_we_n), 32'd0);
    clr_n = 1'b0; #1;
    chk("async_we_n", 32'(mem_we_n), 32'd1);
    chk("async_drive", 32'(mem_drive), 32'd0);
    chk("async_ce_n", 32'(mem_ce_n), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk);

    run(0, 5, 1'b0);
    chk("log5_n", 32'(log5.size()), 32'd2);
    if (log5.size() == 2) begin
      chk("log5_p0", 32'(log5[0]), 32'h0000A5C6);
      chk("log5_p1", 32'(log5[1]), 32'h00005A39);
    end
    chk("good_err", 32'(err_count), 32'd0);
    chk("good_pass", 32'(pass), 32'd1);
    chk("good_disp", 32'(disp), 32'd0);

    run(1, 5, 1'b1);
    chk("bit3_err", 32'(err_count), 32'd1);
    chk("bit3_pass", 32'(pass), 32'd0);
`ifdef SRAM_TEST_FIRST_FAIL_EN
    chk("bit3_ff", 32'(first_fail), 32'h5);
    chk("bit3_disp", 32'(disp), 32'h5);
`else
    chk("bit3_disp", 32'(disp), 32'h1);
`endif

    run(2, 5, 1'b0);
    chk("stuck_err", 32'(err_count), 32'h20);
    chk("stuck_pass", 32'(pass), 32'd0);

    for (int i = 0; i < 3; i++) run(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)), 1'(i & 1));
    run(0, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
